frame_deframer: RTL and testbench

Receive-side deframer between a UART byte receiver and the frame-level logic of each interface channel (plain and secret).
- Consumes a stream of raw bytes and strips byte stuffing.
- Assembles one fixed-size frame of preamble, data and CRC.
- Checks the CRC and length, then presents the whole frame as one wide word with a single-cycle valid strobe and a confirmation code.
- One instance per channel.

---
 rtl/frame_pkg.sv | 33 +++
 rtl/crc32_byte.sv | 19 +
 rtl/frame_deframer.sv | 134 +++++++++++++
 tb/tb_frame_deframer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared constants, codes and state encoding for the receive-side frame deframer.
package frame_pkg;

  localparam int DATA_SIZE     = 64;
  localparam int PREAMBLE_SIZE = 7;
  localparam int CRC_SIZE      = 4;
  localparam int FRAME_BYTES   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE;
  localparam int FRAME_SIZE    = FRAME_BYTES * 8;
  localparam int CRC_START     = PREAMBLE_SIZE + DATA_SIZE;
  localparam int CNT_W         = 7;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] CRC_POS   = CNT_W'(CRC_START);

  localparam logic [7:0] FRAME_START = 8'h06;
  localparam logic [7:0] FRAME_END   = 8'h07;
  localparam logic [7:0] ESC_VAL     = 8'h14;
  localparam logic [7:0] ESC_XOR     = 8'h20;
  localparam logic [7:0] OKAY        = 8'h05;
  localparam logic [7:0] ERROR       = 8'h04;

  localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    ESC,
    CHECK
  } state_t;

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32 (IEEE) register.
module crc32_byte
  import frame_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  always_comb begin : crc_step
    logic [31:0] w_acc;
    w_acc = crc_in ^ {24'd0, data_in};
    for (int i = 0; i < 8; i++) begin
      w_acc = w_acc[0] ? ((w_acc >> 1) ^ CRC_POLY) : (w_acc >> 1);
    end
    crc_out = w_acc;
  end

endmodule

// File: rtl/frame_deframer.sv
// Byte-stuffed frame receiver: destuffs, assembles a 75-byte frame, checks length
// and (with FRAME_DEFRAMER_CRC_CHECK_EN defined) the CRC-32, then strobes it out.
module frame_deframer
  import frame_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [0:FRAME_SIZE-1] fout,
  output logic                  fout_valid,
  output logic [7:0]            conf_code,
  output logic                  conf_valid,
  output logic                  busy
);

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [0:FRAME_SIZE-1] r_shadow, r_fout;
  logic                  r_fout_valid, r_conf_valid;
  logic [7:0]            r_conf_code;

  logic       w_init, w_store, w_abort, w_crc_ok;
  logic       w_fout_v, w_conf_v;
  logic [7:0] w_store_byte, w_code;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_init       = 1'b0;
    w_store      = 1'b0;
    w_abort      = 1'b0;
    w_store_byte = rx_byte;
    w_conf_v     = 1'b0;
    w_fout_v     = 1'b0;
    w_code       = r_conf_code;

    case (r_state)
      IDLE: if (rx_valid && rx_byte == FRAME_START) begin
        w_init       = 1'b1;
        w_state_next = RECV;
      end
      RECV: if (rx_valid) begin
        if (rx_byte == FRAME_START)    w_init = 1'b1;
        else if (rx_byte == FRAME_END) w_state_next = CHECK;
        else if (rx_byte == ESC_VAL)   w_state_next = ESC;
        else                           w_store = 1'b1;
      end
      ESC: if (rx_valid) begin
        if (rx_byte == FRAME_START || rx_byte == FRAME_END) begin
          w_abort = 1'b1;
        end else begin
          w_store      = 1'b1;
          w_store_byte = rx_byte ^ ESC_XOR;
          w_state_next = RECV;
        end
      end
      CHECK: begin
        w_state_next = IDLE;
        w_conf_v     = 1'b1;
        w_fout_v     = (r_cnt == FRAME_LEN) && w_crc_ok;
        w_code       = w_fout_v ? OKAY : ERROR;
      end
      default: w_state_next = IDLE;
    endcase

    // A byte that would land past the CRC field kills the frame on the spot.
    if (w_store && r_cnt == FRAME_LEN) begin
      w_store = 1'b0;
      w_abort = 1'b1;
    end
    if (w_store) w_cnt_next = r_cnt + CNT_W'(1);
    if (w_init)  w_cnt_next = '0;
    if (w_abort) begin
      w_state_next = IDLE;
      w_conf_v     = 1'b1;
      w_code       = ERROR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_fout       <= '0;
      r_fout_valid <= 1'b0;
      r_conf_valid <= 1'b0;
      r_conf_code  <= OKAY;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_fout_valid <= w_fout_v;
      r_conf_valid <= w_conf_v;
      r_conf_code  <= w_code;
      if (w_fout_v) r_fout <= r_shadow;
    end
  end

  // NOTE: the shadow frame needs no reset; it is only published after all 75 positions were rewritten.
  always_ff @(posedge clk) begin
    if (w_store) r_shadow[{r_cnt, 3'b000} +: 8] <= w_store_byte;
  end

`ifdef FRAME_DEFRAMER_CRC_CHECK_EN
  logic [31:0] r_crc, w_crc_upd;

  crc32_byte u_crc (
    .crc_in  (r_crc),
    .data_in (w_store_byte),
    .crc_out (w_crc_upd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_crc <= CRC_INIT;
    else if (w_init)                        r_crc <= CRC_INIT;
    else if (w_store && r_cnt < CRC_POS)    r_crc <= w_crc_upd;
  end

  // Received CRC field is little-endian: lowest address carries crc[7:0].
  assign w_crc_ok = ((r_crc ^ CRC_XOROUT) ==
                     {r_shadow[(CRC_START+3)*8 +: 8], r_shadow[(CRC_START+2)*8 +: 8],
                      r_shadow[(CRC_START+1)*8 +: 8], r_shadow[CRC_START*8 +: 8]});
`else
  assign w_crc_ok = 1'b1;
`endif

  assign fout       = r_fout;
  assign fout_valid = r_fout_valid;
  assign conf_code  = r_conf_code;
  assign conf_valid = r_conf_valid;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_frame_deframer.sv
// Randomized and directed bench for frame_deframer against a queue-based frame model.
module tb_frame_deframer;
  import frame_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef logic [0:FRAME_SIZE-1] frame_t;
  typedef struct {
    logic [7:0] code;
    bit         fv;
    frame_t     frame;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  frame_t     fout;
  logic       fout_valid, conf_valid, busy;
  logic [7:0] conf_code;

  int tests = 0, fails = 0, cyc = 0, obs_ok = 0, obs_err = 0;

  ev_t    exp_ev[int];
  frame_t model_fout = '0;
  int     m_mode = 0;  // 0 outside a frame, 1 inside, 2 after an escape byte
  bq_t    m_buf;
  ev_t    cmp_e;

  frame_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .fout       (fout),
    .fout_valid (fout_valid),
    .conf_code  (conf_code),
    .conf_valid (conf_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_frame(input string name, input frame_t act, input frame_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t q, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic frame_t to_frame(input bq_t q);
    frame_t f;
    f = '0;
    for (int k = 0; k < 75; k++) f = {f[8:FRAME_SIZE-1], q[k]};
    return f;
  endfunction

  function automatic bit model_crc_ok(input bq_t q);
`ifdef FRAME_DEFRAMER_CRC_CHECK_EN
    return crc32(q, 71) == {q[74], q[73], q[72], q[71]};
`else
    return 1'b1;
`endif
  endfunction

  function automatic bq_t make_raw(input bq_t pay);
    bq_t r;
    logic [31:0] c;
    r = pay;
    c = crc32(pay, 71);
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    r.push_back(c[23:16]);
    r.push_back(c[31:24]);
    return r;
  endfunction

  function automatic bq_t encode(input bq_t raw);
    bq_t o;
    o.push_back(8'h06);
    foreach (raw[i]) begin
      if (raw[i] == 8'h06 || raw[i] == 8'h07 || raw[i] == 8'h14) begin
        o.push_back(8'h14);
        o.push_back(raw[i] ^ 8'h20);
      end else begin
        o.push_back(raw[i]);
      end
    end
    o.push_back(8'h07);
    return o;
  endfunction

  task automatic model_abort(input int c);
    ev_t e;
    e.fv = 1'b0; e.code = 8'h04; e.frame = '0;
    exp_ev[c+1] = e;
    m_mode = 0;
  endtask

  task automatic model_push(input logic [7:0] b, input int c);
    if (m_buf.size() == 75) model_abort(c);
    else m_buf.push_back(b);
  endtask

  // Expected pulses: abort one cycle after the byte, end-of-frame verdict two cycles after.
  task automatic model_byte(input logic [7:0] b, input int c);
    ev_t e;
    case (m_mode)
      0: if (b == 8'h06) begin m_buf.delete(); m_mode = 1; end
      1: begin
        if (b == 8'h06) m_buf.delete();
        else if (b == 8'h07) begin
          e.fv    = (m_buf.size() == 75) && model_crc_ok(m_buf);
          e.code  = e.fv ? 8'h05 : 8'h04;
          e.frame = e.fv ? to_frame(m_buf) : '0;
          exp_ev[c+2] = e;
          m_mode = 0;
        end
        else if (b == 8'h14) m_mode = 2;
        else model_push(b, c);
      end
      default: begin
        if (b == 8'h06 || b == 8'h07) model_abort(c);
        else begin m_mode = 1; model_push(b ^ 8'h20, c); end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_ev.exists(cyc)) begin
        cmp_e = exp_ev[cyc];
        exp_ev.delete(cyc);
        check("conf_valid pulse", 64'(conf_valid), 64'd1);
        check("conf_code", 64'(conf_code), 64'(cmp_e.code));
        check("fout_valid pulse", 64'(fout_valid), 64'(cmp_e.fv));
        if (cmp_e.fv) model_fout = cmp_e.frame;
      end else begin
        check("conf_valid quiet", 64'(conf_valid), 64'd0);
        check("fout_valid quiet", 64'(fout_valid), 64'd0);
      end
      check_frame("fout", fout, model_fout);
      if (conf_valid) begin
        if (conf_code == 8'h05) obs_ok++;
        else obs_err++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    @(negedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    model_byte(b, cyc);
    @(negedge clk); #1;
    rx_valid = 1'b0; rx_byte = 8'($urandom);
    g = $urandom_range(0, 2);
    repeat (g) @(negedge clk);
  endtask

  task automatic send_seq(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " fout_valid"}, 64'(fout_valid), 64'd0);
    check({tag, " conf_valid"}, 64'(conf_valid), 64'd0);
    check({tag, " conf_code"}, 64'(conf_code), 64'h05);
    check_frame({tag, " fout"}, fout, '0);
  endtask

  initial begin
    bq_t ref_pay, ref_raw, q, enc;
    int ok0, err0, kind, pos;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;

    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc32 check value", 64'(crc32(q, 9)), 64'hCBF43926);

    // Noise before any start flag
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      if (b == 8'h06) b = 8'h55;
      send_byte(b);
    end
    settle();
    check("idle noise busy", 64'(busy), 64'd0);
    check("idle noise no conf", 64'(obs_ok + obs_err), 64'd0);

    // Reference frame
    for (int k = 0; k < 71; k++) ref_pay.push_back(8'(k));
    ref_raw = make_raw(ref_pay);
    send_seq(encode(ref_raw));
    settle();
    check("ref ok count", 64'(obs_ok), 64'd1);
    check("ref err count", 64'(obs_err), 64'd0);
    check("ref conf_code", 64'(conf_code), 64'h05);
    for (int k = 0; k < 71; k++) check("ref fout byte", 64'(fout[8*k +: 8]), 64'(k));

    // One data bit flipped
    ok0 = obs_ok; err0 = obs_err;
    q = ref_raw;
    q[20] = q[20] ^ 8'h10;
    send_seq(encode(q));
    settle();
`ifdef FRAME_DEFRAMER_CRC_CHECK_EN
    check("bitflip conf_code", 64'(conf_code), 64'h04);
    check("bitflip err count", 64'(obs_err - err0), 64'd1);
    check("bitflip fout kept", 64'(fout[8*20 +: 8]), 64'd20);
`else
    check("bitflip conf_code", 64'(conf_code), 64'h05);
    check("bitflip ok count", 64'(obs_ok - ok0), 64'd1);
`endif

    // 74 bytes then end flag
    err0 = obs_err;
    q = ref_raw;
    void'(q.pop_back());
    send_seq(encode(q));
    settle();
    check("short conf_code", 64'(conf_code), 64'h04);
    check("short err count", 64'(obs_err - err0), 64'd1);

    // 76th byte, no end flag
    err0 = obs_err;
    q = ref_raw;
    q.push_back(8'h55);
    enc = encode(q);
    void'(enc.pop_back());
    send_seq(enc);
    settle();
    check("overflow err count", 64'(obs_err - err0), 64'd1);
    check("overflow busy", 64'(busy), 64'd0);

    // Escape followed by end flag, then a good frame
    ok0 = obs_ok; err0 = obs_err;
    send_seq({8'h06, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h07});
    send_seq(encode(ref_raw));
    settle();
    check("esc abort err count", 64'(obs_err - err0), 64'd1);
    check("esc recovery ok count", 64'(obs_ok - ok0), 64'd1);

    // Restart mid-frame at byte 30
    ok0 = obs_ok; err0 = obs_err;
    q = {8'h06};
    for (int k = 0; k < 30; k++) q.push_back(8'h40 + 8'(k));
    send_seq(q);
    check("mid-frame busy", 64'(busy), 64'd1);
    send_seq(encode(ref_raw));
    settle();
    check("restart ok count", 64'(obs_ok - ok0), 64'd1);
    check("restart err count", 64'(obs_err - err0), 64'd0);

    // Random frames
    for (int n = 0; n < 12; n++) begin
      q.delete();
      for (int k = 0; k < 71; k++) q.push_back(8'($urandom));
      q = make_raw(q);
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        pos = $urandom_range(0, 74);
        q[pos] = q[pos] ^ (8'h01 << $urandom_range(0, 7));
      end else if (kind == 2) begin
        pos = $urandom_range(1, 15);
        repeat (pos) void'(q.pop_back());
      end else if (kind == 3) begin
        pos = $urandom_range(1, 3);
        repeat (pos) q.push_back(8'($urandom));
      end
      for (int i = 0; i < $urandom_range(0, 4); i++) begin
        b = 8'($urandom);
        if (b == 8'h06) b = 8'h00;
        send_byte(b);
      end
      send_seq(encode(q));
    end
    settle();

    // Reset in the middle of a frame
    enc = encode(ref_raw);
    for (int i = 0; i < 41; i++) send_byte(enc[i]);
    @(negedge clk); #1;
    rst = 1'b1;
    m_mode = 0; m_buf.delete(); exp_ev.delete(); model_fout = '0;
    #1 check_reset_outputs("mid-frame reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    ok0 = obs_ok;
    send_seq(encode(ref_raw));
    settle();
    check("post-reset ok count", 64'(obs_ok - ok0), 64'd1);
    check("post-reset conf_code", 64'(conf_code), 64'h05);

    repeat (4) @(negedge clk);
    check("pending expectations", 64'(exp_ev.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
